// File: rtl/cache_pkg.sv
// Shared types for the cache miss/refill path: address split, block storage
// and the refill sequencer state encoding.
package cache_pkg;

    localparam int unsigned CACHE_ADDR_BITS   = 10;
    localparam int unsigned CACHE_DATA_BITS   = 32;
    localparam int unsigned CACHE_BLOCK_BITS  = 2;
    localparam int unsigned CACHE_INDEX_BITS  = 4;
    localparam int unsigned CACHE_BLOCK_WORDS = 2 ** CACHE_BLOCK_BITS;
    localparam int unsigned CACHE_TAG_BITS    = CACHE_ADDR_BITS - CACHE_INDEX_BITS - CACHE_BLOCK_BITS;

    typedef struct packed {
        logic [CACHE_TAG_BITS-1:0]   tag;
        logic [CACHE_INDEX_BITS-1:0] index;
        logic [CACHE_BLOCK_BITS-1:0] offset;
    } cache_addr_t;

    typedef logic [CACHE_DATA_BITS-1:0] block_t [CACHE_BLOCK_WORDS];

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        RD_REQ,
        RD_WAIT,
        DONE
    } refill_state_e;

endpackage

// File: rtl/cache_wr_buffer.sv
// Single-entry write-through buffer; loads when empty, empties on the
// refill sequencer's write-grant pulse.
module cache_wr_buffer #(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_address,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 clear,
    output logic                 wr_ready,
    output logic                 wb_valid,
    output logic [ADDR_BITS-1:0] wb_address,
    output logic [DATA_BITS-1:0] wb_data
);

    // wr_ready is kept as its own flop so the cache sees a registered signal.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid   <= 1'b0;
            wr_ready   <= 1'b1;
            wb_address <= '0;
            wb_data    <= '0;
        end else if (wr_en && wr_ready) begin
            wb_valid   <= 1'b1;
            wr_ready   <= 1'b0;
            wb_address <= wr_address;
            wb_data    <= wr_data;
        end else if (clear) begin
            wb_valid   <= 1'b0;
            wr_ready   <= 1'b1;
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss/refill sequencer: drains the write buffer, then fetches a block
// critical word first and hands it to the cache as a one-cycle refill pulse.
module cache_refill_ctrl #(
    parameter int unsigned RAM_ADDRESS_BITS = 10,
    parameter int unsigned DATA_BITS        = 32,
    parameter int unsigned BLOCK_BITS       = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        miss,
    input  logic [RAM_ADDRESS_BITS-1:0] miss_address,
    input  logic                        wr_en,
    input  logic [RAM_ADDRESS_BITS-1:0] wr_address,
    input  logic [DATA_BITS-1:0]        wr_data,
    output logic                        wr_ready,
    output logic                        busy,
    output logic                        refill_valid,
    output logic [RAM_ADDRESS_BITS-1:0] refill_address,
    output logic [DATA_BITS-1:0]        refill_data [2**BLOCK_BITS],
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [RAM_ADDRESS_BITS-1:0] mem_address,
    output logic [DATA_BITS-1:0]        mem_wdata,
    input  logic                        mem_gnt,
    input  logic                        mem_rvalid,
    input  logic [DATA_BITS-1:0]        mem_rdata
);

    import cache_pkg::*;

    localparam int unsigned BLOCK_WORDS = 2 ** BLOCK_BITS;
    localparam int unsigned BASE_BITS   = RAM_ADDRESS_BITS - BLOCK_BITS;

    logic                        wb_valid;
    logic [RAM_ADDRESS_BITS-1:0] wb_address;
    logic [DATA_BITS-1:0]        wb_data;
    logic                        wb_clear;
    logic                        take_miss;
    refill_state_e               state;
    logic [BASE_BITS-1:0]        miss_base;
    logic [BLOCK_BITS-1:0]       miss_off;
    logic [BLOCK_BITS-1:0]       count;
    logic [BLOCK_BITS-1:0]       word_off;

    cache_wr_buffer #(
        .ADDR_BITS (RAM_ADDRESS_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_wr_buffer (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .clear      (wb_clear),
        .wr_ready   (wr_ready),
        .wb_valid   (wb_valid),
        .wb_address (wb_address),
        .wb_data    (wb_data)
    );

    // busy doubles as the "miss latched" flag while a buffered write drains.
    always_comb begin
        wb_clear  = (state == WR_REQ) && mem_gnt;
        take_miss = miss && !busy && ((state == IDLE) || (state == WR_REQ));
        word_off  = miss_off + count;
    end

    // mem_* outputs are loaded one state ahead so a request is on the port
    // in the same cycle the FSM enters its REQ state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            refill_valid   <= 1'b0;
            refill_address <= '0;
            for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
                refill_data[i] <= '0;
            end
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_address    <= '0;
            mem_wdata      <= '0;
            miss_base      <= '0;
            miss_off       <= '0;
            count          <= '0;
        end else begin
            refill_valid <= 1'b0;
            if (take_miss) begin
                miss_base <= miss_address[RAM_ADDRESS_BITS-1:BLOCK_BITS];
                miss_off  <= miss_address[BLOCK_BITS-1:0];
                count     <= '0;
                busy      <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (wb_valid) begin
                        state       <= WR_REQ;
                        mem_req     <= 1'b1;
                        mem_we      <= 1'b1;
                        mem_address <= wb_address;
                        mem_wdata   <= wb_data;
                    end else if (miss) begin
                        state       <= RD_REQ;
                        mem_req     <= 1'b1;
                        mem_we      <= 1'b0;
                        mem_address <= miss_address;
                    end
                end
                WR_REQ: begin
                    if (mem_gnt) begin
                        if (busy) begin
                            state       <= RD_REQ;
                            mem_req     <= 1'b1;
                            mem_we      <= 1'b0;
                            mem_address <= {miss_base, miss_off};
                        end else if (miss) begin
                            state       <= RD_REQ;
                            mem_req     <= 1'b1;
                            mem_we      <= 1'b0;
                            mem_address <= miss_address;
                        end else begin
                            state       <= IDLE;
                            mem_req     <= 1'b0;
                            mem_we      <= 1'b0;
                        end
                    end
                end
                RD_REQ: begin
                    if (mem_gnt) begin
                        state   <= RD_WAIT;
                        mem_req <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid) begin
                        refill_data[word_off] <= mem_rdata;
                        count                 <= count + BLOCK_BITS'(1);
                        if (count == BLOCK_BITS'(BLOCK_WORDS - 1)) begin
                            state <= DONE;
                        end else begin
                            state       <= RD_REQ;
                            mem_req     <= 1'b1;
                            mem_address <= {miss_base, word_off + BLOCK_BITS'(1)};
                        end
                    end
                end
                DONE: begin
                    refill_valid   <= 1'b1;
                    refill_address <= {miss_base, {BLOCK_BITS{1'b0}}};
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: RAM responder with programmable grant/read
// latency, table-driven and random refills, plus hand-written corner cases.
module tb_cache_refill_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        miss;
    logic [9:0]  miss_address;
    logic        wr_en;
    logic [9:0]  wr_address;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        busy;
    logic        refill_valid;
    logic [9:0]  refill_address;
    logic [31:0] refill_data [4];
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_address;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    cache_refill_ctrl #(
        .RAM_ADDRESS_BITS (10),
        .DATA_BITS        (32),
        .BLOCK_BITS       (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .miss           (miss),
        .miss_address   (miss_address),
        .wr_en          (wr_en),
        .wr_address     (wr_address),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .busy           (busy),
        .refill_valid   (refill_valid),
        .refill_address (refill_address),
        .refill_data    (refill_data),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] addr;
        int         g;
        int         r;
        int         lat;
        logic [9:0] base;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] ram [1024];
    logic [41:0] exp_wq [$];
    logic [9:0]  rd_log [$];
    logic [10:0] txn_q [$];
    int          gnt_lat_cfg = 0;
    int          rv_lat_cfg = 1;
    int          gnt_wait = 0;
    int          rd_wait = 0;
    logic [9:0]  rd_addr;
    bit          req_active = 0;
    int          inject_cnt = 0;
    int          inject_done = 0;
    int          last_wr_grant_cyc = -1;
    int          last_refill_cyc = -1;
    logic [31:0] last_blk [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // RAM responder (drives at posedge+1) and bus monitor (samples at negedge)
    bit          hold_prev = 0;
    bit          rst_prev = 0;
    logic        hold_we;
    logic [9:0]  hold_addr;
    logic [31:0] hold_wdata;
    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            mem_rvalid = 1'b0;
            if (rd_wait > 0) begin
                rd_wait--;
                if (rd_wait == 0) begin mem_rvalid = 1'b1; mem_rdata = ram[rd_addr]; end
            end
            if (inject_cnt != inject_done) begin
                inject_done++;
                mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
            end
            mem_gnt = 1'b0;
            if (mem_req) begin
                if (!req_active) begin req_active = 1; gnt_wait = gnt_lat_cfg; end
                if (gnt_wait == 0) mem_gnt = 1'b1; else gnt_wait--;
            end else begin
                req_active = 0;
            end
            @(negedge clk);
            if (hold_prev && !rst_prev)
                check("req_held_stable", {mem_req, mem_we, mem_address, mem_wdata},
                      {1'b1, hold_we, hold_addr, hold_wdata});
            hold_prev  = mem_req && !mem_gnt;
            hold_we    = mem_we;
            hold_addr  = mem_address;
            hold_wdata = mem_wdata;
            rst_prev   = reset;
            if (mem_req && mem_gnt) begin
                req_active = 0;
                txn_q.push_back({mem_we, mem_address});
                if (mem_we) begin
                    ram[mem_address] = mem_wdata;
                    last_wr_grant_cyc = cyc;
                    if (exp_wq.size() == 0) check("unexpected_write", {mem_address, mem_wdata}, 0);
                    else check("write_order", {mem_address, mem_wdata}, exp_wq.pop_front());
                end else begin
                    rd_log.push_back(mem_address);
                    rd_addr = mem_address;
                    rd_wait = rv_lat_cfg;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 400) begin @(negedge clk); n++; end
        if (busy) check("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_drained();
        int n = 0;
        @(negedge clk);
        while ((exp_wq.size() != 0 || !wr_ready) && n < 400) begin @(negedge clk); n++; end
        check("writes_drained", exp_wq.size(), 0);
        @(negedge clk);
    endtask

    task automatic do_write(input logic [9:0] a, input logic [31:0] d,
                            output int waited, output int acc_cyc, output int prev_grant);
        waited = 0;
        @(posedge clk); #1;
        wr_en = 1'b1; wr_address = a; wr_data = d;
        @(negedge clk);
        while (!wr_ready && waited < 400) begin @(negedge clk); waited++; end
        if (!wr_ready) check("write_accept_timeout", 0, 1);
        acc_cyc    = cyc;
        prev_grant = last_wr_grant_cyc;
        exp_wq.push_back({a, d});
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic do_miss(input logic [9:0] a, input int g, input int r,
                           input int exp_lat, input bit chk_lat, input bit drain);
        int         n;
        logic [9:0] base;
        logic [9:0] exp_a;
        gnt_lat_cfg = g;
        rv_lat_cfg  = r;
        if (drain) wait_drained();
        wait_idle();
        rd_log.delete();
        base = a & 10'h3FC;
        @(posedge clk); #1;
        miss = 1'b1; miss_address = a;
        @(negedge clk);
        n = 0;
        while (n < 400) begin
            @(posedge clk); #1;
            miss = 1'b0;
            n++;
            @(negedge clk);
            if (n == 1) check("busy_after_miss", busy, 1);
            if (refill_valid) break;
        end
        if (!refill_valid) begin
            check("refill_timeout", 0, 1);
            return;
        end
        last_refill_cyc = cyc;
        if (chk_lat) check("refill_latency", n, exp_lat);
        check("busy_drop_at_refill", busy, 0);
        check("refill_address", refill_address, base);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("refill_data[%0d]", i), refill_data[i], ram[base + 10'(i)]);
            last_blk[i] = ram[base + 10'(i)];
        end
        check("read_count", rd_log.size(), 4);
        for (int k = 0; k < 4 && k < rd_log.size(); k++) begin
            exp_a = base | ((a + 10'(k)) & 10'h003);
            check($sformatf("read_order[%0d]", k), rd_log[k], exp_a);
        end
        @(negedge clk);
        check("refill_pulse_width", refill_valid, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_wr_ready"}, wr_ready, 1);
        check({tag, "_refill_valid"}, refill_valid, 0);
        check({tag, "_refill_address"}, refill_address, 0);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_refill_data[%0d]", tag, i), refill_data[i], 0);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_address"}, mem_address, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        vec_t vecs [6];
        int   w1, a1, p1, w2, a2, p2;
        int   n;
        int   nrd;
        bit   saw_refill;
        logic [9:0] ma;
        int   g, r;

        vecs[0] = '{10'h013, 0, 1, 10, 10'h010};
        vecs[1] = '{10'h3FE, 0, 1, 10, 10'h3FC};
        vecs[2] = '{10'h000, 1, 1, 14, 10'h000};
        vecs[3] = '{10'h155, 0, 3, 18, 10'h154};
        vecs[4] = '{10'h0C2, 2, 2, 22, 10'h0C0};
        vecs[5] = '{10'h0E6, 5, 1, 30, 10'h0E4};

        for (int i = 0; i < 1024; i++) ram[i] = 32'h100 + 32'(i);
        reset = 1'b1; miss = 1'b0; miss_address = '0;
        wr_en = 1'b0; wr_address = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // table-driven refills, zero-wait and stalled RAM
        foreach (vecs[i]) begin
            do_miss(vecs[i].addr, vecs[i].g, vecs[i].r, vecs[i].lat, 1, 1);
            check($sformatf("vec%0d_base", i), refill_address, vecs[i].base);
        end

        // spurious rvalid while idle
        inject_cnt++;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            check($sformatf("spurious_rvalid_data[%0d]", i), refill_data[i], last_blk[i]);
        check("spurious_rvalid_busy", busy, 0);
        check("spurious_rvalid_req", mem_req, 0);

        // buffered write drains before a miss that arrives behind it
        wait_drained();
        txn_q.delete();
        do_write(10'h020, 32'h0000_DEAD, w1, a1, p1);
        do_miss(10'h024, 0, 1, 10, 1, 0);
        check("wr_then_miss_txns", txn_q.size(), 5);
        if (txn_q.size() >= 2) begin
            check("wr_then_miss_first", txn_q[0], {1'b1, 10'h020});
            check("wr_then_miss_second", txn_q[1], {1'b0, 10'h024});
        end
        check("ram_written", ram[10'h020], 32'h0000_DEAD);

        // second write while buffer full, during a refill
        wait_drained();
        fork
            do_miss(10'h040, 0, 1, 10, 1, 0);
            begin
                repeat (3) @(posedge clk);
                do_write(10'h300, 32'hA5A5_0001, w1, a1, p1);
                do_write(10'h304, 32'hA5A5_0002, w2, a2, p2);
            end
        join
        check("second_write_blocked", (w2 > 0), 1);
        check("first_write_drain_cycle", p2, last_refill_cyc + 1);
        check("second_write_accept_cycle", a2, p2 + 1);
        wait_drained();
        check("ram_second_write", ram[10'h304], 32'hA5A5_0002);

        // reset while waiting for the third word; its rvalid arrives late
        gnt_lat_cfg = 0; rv_lat_cfg = 4;
        wait_idle();
        rd_log.delete();
        @(posedge clk); #1;
        miss = 1'b1; miss_address = 10'h0A1;
        @(posedge clk); #1;
        miss = 1'b0;
        n = 0;
        nrd = 0;
        while (nrd < 3 && n < 200) begin @(negedge clk); n++; nrd = rd_log.size(); end
        check("reset_test_reads_reached", nrd, 3);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("midreset");
        saw_refill = 0;
        repeat (8) begin
            @(negedge clk);
            if (refill_valid || busy) saw_refill = 1;
        end
        check("midreset_no_refill", saw_refill, 0);
        for (int i = 0; i < 4; i++)
            check($sformatf("midreset_stray_data[%0d]", i), refill_data[i], 0);
        do_miss(10'h0A1, 0, 1, 10, 1, 1);

        // random refills, some preceded by a buffered write
        for (int it = 0; it < 40; it++) begin
            ma = 10'($urandom_range(0, 511));
            g  = int'($urandom_range(0, 2));
            r  = int'($urandom_range(1, 3));
            if ($urandom_range(0, 2) == 0) begin
                do_write(10'h200 + 10'($urandom_range(0, 511)), $urandom, w1, a1, p1);
                do_miss(ma, g, r, 0, 0, 0);
            end else begin
                do_miss(ma, g, r, 2 + 4 * (g + r + 1), 1, 1);
            end
        end
        wait_drained();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Miss/refill sequencer between the cache and word-wide RAM. It accepts a read miss from the cache and fetches the whole block from RAM one word at a time, critical word first with wrap-around. It then returns the block to the cache as a one-cycle refill pulse. It also holds a single-entry write-through buffer that shares the RAM port with refills.

Parameters:
RAM_ADDRESS_BITS, 10, word address width of RAM and of the cache address
DATA_BITS, 32, word width
BLOCK_BITS, 2, log2 of words per block; BLOCK_WORDS = 2**BLOCK_BITS (exponent, not square)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
miss  in  1  cache read miss request; sampled only when busy=0
miss_address  in  RAM_ADDRESS_BITS  word address that missed
wr_en  in  1  write-through request; accepted when wr_en && wr_ready
wr_address  in  RAM_ADDRESS_BITS  write word address
wr_data  in  DATA_BITS  write word
wr_ready  out  1  write buffer empty
busy  out  1  refill in progress; cache/CPU stalls
refill_valid  out  1  one-cycle pulse: refill_data holds the complete block
refill_address  out  RAM_ADDRESS_BITS  block-aligned address (offset bits zero)
refill_data  out  DATA_BITS x BLOCK_WORDS  unpacked array indexed by block offset
mem_req  out  1  RAM request; held until mem_gnt
mem_we  out  1  1=write, 0=read
mem_address  out  RAM_ADDRESS_BITS  RAM word address
mem_wdata  out  DATA_BITS  RAM write data
mem_gnt  in  1  RAM accepts request this cycle (mem_req && mem_gnt)
mem_rvalid  in  1  read data valid, at least 1 cycle after grant
mem_rdata  in  DATA_BITS  read data

Behaviour:
- Reset values: busy=0, wr_ready=1, refill_valid=0, refill_address=0, refill_data all 0, mem_req=0, mem_we=0, mem_address=0, mem_wdata=0. Reset also clears the write buffer, the word counter and the FSM (state IDLE). Reset mid-refill abandons the refill: no refill_valid, and a late mem_rvalid is ignored.
- Write buffer: one entry (address, data, valid). It loads on wr_en && wr_ready in any state. wr_ready = !wb_valid, a registered output. It clears in the cycle after the write grant, so it can reload one cycle after the grant.
- FSM states: IDLE, WR_REQ, RD_REQ, RD_WAIT, DONE.
- IDLE: if wb_valid, go to WR_REQ. The write drains before the refill so a refill never returns stale data. Else if miss, latch miss_address, set the word counter to 0, and go to RD_REQ. busy goes high the cycle after miss is sampled. A miss that arrives while a write drains is latched and busy=1 immediately; the read is issued after the write completes.
- WR_REQ: mem_req=1, mem_we=1, buffer address/data on the mem_* outputs. On mem_gnt, clear wb_valid. Then go to RD_REQ if a miss is latched, else IDLE. Writes need no response.
- RD_REQ: mem_req=1, mem_we=0, mem_address = {tag/index of miss, (miss offset + count) mod BLOCK_WORDS}. The offset wraps, e.g. offset 3 with BLOCK_BITS=2 reads 3,0,1,2. On mem_gnt, go to RD_WAIT. mem_* outputs stay stable while mem_req && !mem_gnt.
- RD_WAIT: on mem_rvalid, store mem_rdata into refill_data[word offset] and increment count. When count reaches BLOCK_WORDS-1 go to DONE, else go to RD_REQ. Exactly one read is outstanding at a time. mem_rvalid in any other state is ignored.
- DONE: refill_valid=1 for exactly one cycle, and refill_address = miss_address with the offset bits zeroed. busy drops in the same cycle. Return to IDLE. refill_data holds its value until the next refill overwrites it.
- Writes arriving during a refill are buffered only and drain in the next IDLE. A write to the block being refilled is the cache's responsibility to merge.
- Latency with zero-wait RAM (grant in the same cycle as req, rvalid one cycle after grant): miss to refill_valid = 1 + 2*BLOCK_WORDS + 1 cycles (10 for the defaults).

Decomposition:
- Package cache_pkg: BLOCK_WORDS, the TAG/INDEX/offset split of the address as a packed struct, the state enum, and block_t (unpacked word array) shared with the cache.
- One sub-module: cache_wr_buffer, the single-entry buffer with its load/clear handshake. The FSM stays in the top.

Test Plan:
- Miss at 0x013 (offset 3), RAM returns data = address+0x100, zero-wait -> reads issued at 0x013,0x010,0x011,0x012; refill_valid at cycle 10, refill_address=0x010, refill_data[0..3]=0x110,0x111,0x112,0x113.
- Write 0x020 ← 0xDEAD pending, miss 0x024 in the same cycle -> mem write 0x020 granted first, then reads 0x024..0x027; busy=1 from the cycle after the miss is sampled.
- mem_gnt held low 5 cycles during RD_REQ -> mem_req/mem_address stable all 5 cycles, no double issue, final block correct.
- Second wr_en while buffer full -> wr_ready=0, data not lost; the buffer drains after refill_valid, and the second write is accepted the cycle after the buffer clears.
- reset asserted in RD_WAIT after 2 words, then stray mem_rvalid -> no refill_valid, all outputs at reset values, the next miss refills correctly.
- Spurious mem_rvalid in IDLE -> refill_data unchanged, no state change.
